branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Program-counter and branch-resolution stage sitting directly downstream of the 16-bit equality comparator. It holds the fetch PC and advances it on demand. For a conditional branch it stalls one cycle to sample the comparator result `R`, then either redirects to the branch target or falls through. It also keeps saturating branch statistics for debug.

## Interface

Parameters:
- `RESET_PC`, default `16'h0000`: PC value loaded on reset.
- `STEP`, default `16'd2`: PC increment per advance; 16-bit instruction words are byte-addressed.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `Reset_n`  in  1  reset, asynchronous and active-low.
- `advance`  in  1  fetch consumed the current PC; increment PC.
- `br_valid`  in  1  conditional branch present in decode; held by upstream while `stall`=1.
- `jump`  in  1  unconditional jump present in decode.
- `br_target`  in  16  target address for `br_valid`/`jump`.
- `cmp_R`  in  1  comparator result; meaningful only in state WAIT_CMP.
- `pc`  out  16  current fetch PC (registered).
- `stall`  out  1  hold fetch/decode (combinational).
- `flush`  out  1  one-cycle pulse: discard the fetched instruction (registered).
- `br_cnt`  out  8  conditional branches resolved, saturating.
- `taken_cnt`  out  8  conditional branches taken, saturating.

## Operation

- FSM states: RUN, WAIT_CMP. Reset state is RUN.
- Internal registers:
  - `tgt_q[15:0]`: latched branch target.
  - `state`.
- RUN: priority is `jump` > `br_valid` > `advance`.
  - `jump`=1: `pc <= br_target`; `flush <= 1`; stay in RUN. Any `br_valid` or `advance` in the same cycle is ignored.
  - `br_valid`=1 (no jump): `tgt_q <= br_target`; go to WAIT_CMP; `pc` unchanged. `advance` is ignored.
  - `advance`=1 alone: `pc <= pc + STEP`, modulo 2^16. `16'hFFFE + 2` wraps to `16'h0000`.
  - No request: `pc` holds.
- WAIT_CMP: always returns to RUN after exactly one cycle.
  - `cmp_R`=1: `pc <= tgt_q`; `flush <= 1`; `taken_cnt++`; `br_cnt++`.
  - `cmp_R`=0: `pc` unchanged (fall-through); `br_cnt++`; no flush.
  - `advance`, `jump` and `br_valid` are all ignored in WAIT_CMP.
- `stall` = (state==WAIT_CMP) | (state==RUN & `br_valid` & ~`jump`).
- `flush` is 0 in every cycle not stated above.
- Counters saturate at `8'hFF` and never wrap.
- Asynchronous reset, in any state including mid-WAIT_CMP, gives immediately:
  - `pc`=`RESET_PC`, state=RUN, `tgt_q`=0;
  - `flush`=0, `br_cnt`=0, `taken_cnt`=0;
  - `stall`=0 unless `br_valid` is high.
- A `cmp_R` pending at reset is discarded.

## Timing

- Reset values: `pc`=`RESET_PC`, `flush`=0, `br_cnt`=0, `taken_cnt`=0.
- `advance`: `pc` updates on the edge where `advance` is sampled; the new value is visible the next cycle. Throughput is 1 per cycle.
- `jump`: `pc`=target and `flush`=1 both appear in the cycle after `jump` is sampled. Latency is 1.
- Conditional branch:
  - cycle 0: `br_valid` sampled, `stall`=1.
  - cycle 1: WAIT_CMP, `stall`=1, `cmp_R` sampled.
  - cycle 2: RUN, `pc` resolved, `flush`=`cmp_R`.
  - Total latency is 2 cycles.
- `br_valid` must stay high through cycle 0 only; the block latches `br_target` in cycle 0.
- Back-to-back: a new `br_valid` or `jump` may be accepted in cycle 2.
- `stall` is a combinational function of `br_valid`, `jump` and state. No combinational path exists from `cmp_R` to any output.

## Test plan

- Reset, then `advance`=1 for 3 cycles -> `pc` = 0000, 0002, 0004, 0006; `stall`=0 and `flush`=0 throughout.
- `pc`=FFFC, `advance` for 2 cycles -> `pc` = FFFE, then 0000 (wrap).
- `pc`=0010, `br_valid`=1 with `br_target`=0100, `cmp_R`=1 in the next cycle -> `stall`=1 for 2 cycles; `pc`=0100 and `flush`=1 in cycle 2; `br_cnt`=1, `taken_cnt`=1.
- Same stimulus with `cmp_R`=0, and `advance`=1 during the stall -> `pc` stays 0010; `flush`=0; `br_cnt`=1, `taken_cnt`=0.
- `jump`, `br_valid` and `advance` all high, `br_target`=0200 -> `pc`=0200 next cycle; `flush`=1 for one cycle; no WAIT_CMP entered; counters unchanged.
- Two checks on reset and saturation:
  - Assert `Reset_n`=0 while in WAIT_CMP -> `pc`=`RESET_PC` and state=RUN immediately, counters 0.
  - Separately, run 300 taken branches -> `br_cnt`=`taken_cnt`=FF.

Source files
------------

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - fetch PC register with one-cycle conditional branch resolution
//
// Ports:
//   CLK        system clock, rising edge
//   Reset_n    asynchronous active-low reset
//   advance    fetch consumed the current PC; step to the next word
//   br_valid   conditional branch in decode (held by upstream while stall=1)
//   jump       unconditional jump in decode
//   br_target  target address for br_valid / jump
//   cmp_R      equality comparator result, used only in WAIT_CMP
//   pc         current fetch PC (registered)
//   stall      hold fetch/decode (combinational)
//   flush      one-cycle pulse to discard the fetched instruction (registered)
//   br_cnt     conditional branches resolved, saturating
//   taken_cnt  conditional branches taken, saturating

module branch_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] STEP     = 16'd2
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        advance,
  input  logic        br_valid,
  input  logic        jump,
  input  logic [15:0] br_target,
  input  logic        cmp_R,
  output logic [15:0] pc,
  output logic        stall,
  output logic        flush,
  output logic [7:0]  br_cnt,
  output logic [7:0]  taken_cnt
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_CMP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] tgt_q, tgt_d;
  logic        flush_q, flush_d;
  logic [7:0]  br_cnt_q, br_cnt_d;
  logic [7:0]  taken_cnt_q, taken_cnt_d;

  // Saturating increments, precomputed so the FSM body stays readable.
  logic [7:0]  br_cnt_inc;
  logic [7:0]  taken_cnt_inc;

  assign br_cnt_inc    = (br_cnt_q == 8'hFF)    ? br_cnt_q    : br_cnt_q + 8'd1;
  assign taken_cnt_inc = (taken_cnt_q == 8'hFF) ? taken_cnt_q : taken_cnt_q + 8'd1;

  // Stall depends only on state and the decode requests; cmp_R never reaches
  // an output combinationally.
  always_comb begin
    stall = 1'b0;
    if (state_q == WAIT_CMP) begin
      stall = 1'b1;
    end else if (br_valid && !jump) begin
      stall = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    flush_d     = 1'b0;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;

    case (state_q)
      RUN: begin
        if (jump) begin
          pc_d    = br_target;
          flush_d = 1'b1;
        end else if (br_valid) begin
          // Target is captured now so upstream may drop br_valid/br_target
          // once the branch has been accepted.
          tgt_d   = br_target;
          state_d = WAIT_CMP;
        end else if (advance) begin
          pc_d = pc_q + STEP;
        end
      end

      WAIT_CMP: begin
        // Every decode request is ignored here; upstream is stalled.
        state_d  = RUN;
        br_cnt_d = br_cnt_inc;
        if (cmp_R) begin
          pc_d        = tgt_q;
          flush_d     = 1'b1;
          taken_cnt_d = taken_cnt_inc;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      tgt_q       <= 16'h0000;
      flush_q     <= 1'b0;
      br_cnt_q    <= 8'h00;
      taken_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      flush_q     <= flush_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign flush     = flush_q;
  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit with directed vectors

module tb_branch_pc_unit;

  logic        CLK;
  logic        Reset_n;
  logic        advance;
  logic        br_valid;
  logic        jump;
  logic [15:0] br_target;
  logic        cmp_R;
  logic [15:0] pc;
  logic        stall;
  logic        flush;
  logic [7:0]  br_cnt;
  logic [7:0]  taken_cnt;

  branch_pc_unit #(
    .RESET_PC(16'h0000),
    .STEP    (16'd2)
  ) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .advance  (advance),
    .br_valid (br_valid),
    .jump     (jump),
    .br_target(br_target),
    .cmp_R    (cmp_R),
    .pc       (pc),
    .stall    (stall),
    .flush    (flush),
    .br_cnt   (br_cnt),
    .taken_cnt(taken_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] pc;
    logic        stall;
    logic        flush;
    logic [7:0]  bc;
    logic [7:0]  tc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   vec_idx = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act !== req) begin
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: outputs for a vector are sampled mid-cycle, after inputs settle.
  int mon_idx = 0;
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc",        mon_idx, pc,                 e.pc);
      chk("stall",     mon_idx, {15'd0, stall},     {15'd0, e.stall});
      chk("flush",     mon_idx, {15'd0, flush},     {15'd0, e.flush});
      chk("br_cnt",    mon_idx, {8'd0, br_cnt},     {8'd0, e.bc});
      chk("taken_cnt", mon_idx, {8'd0, taken_cnt},  {8'd0, e.tc});
      mon_idx++;
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected during that same cycle.
  task automatic vec(input logic rst_n, input logic adv, input logic bv, input logic jmp,
                     input logic [15:0] tgt, input logic r,
                     input logic [15:0] e_pc, input logic e_st, input logic e_fl,
                     input logic [7:0] e_bc, input logic [7:0] e_tc);
    exp_t e;
    @(posedge CLK);
    #1;
    Reset_n   = rst_n;
    advance   = adv;
    br_valid  = bv;
    jump      = jmp;
    br_target = tgt;
    cmp_R     = r;
    e.pc    = e_pc;
    e.stall = e_st;
    e.flush = e_fl;
    e.bc    = e_bc;
    e.tc    = e_tc;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  initial begin
    int sat;
    Reset_n   = 1'b1;
    advance   = 1'b0;
    br_valid  = 1'b0;
    jump      = 1'b0;
    br_target = 16'h0000;
    cmp_R     = 1'b0;
    #2;
    Reset_n   = 1'b0;

    //   rst adv bv  jmp tgt       R     pc        st   fl   bc     tc
    // Reset state
    vec(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'd0, 8'd0);
    // Sequential advance
    vec(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'd0, 8'd0);
    vec(1, 1, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 8'd0, 8'd0);
    vec(1, 1, 0, 0, 16'h0000, 0, 16'h0004, 0, 0, 8'd0, 8'd0);
    vec(1, 0, 0, 0, 16'h0000, 0, 16'h0006, 0, 0, 8'd0, 8'd0);
    // Jump to FFFC then wrap through FFFE -> 0000
    vec(1, 0, 0, 1, 16'hFFFC, 0, 16'h0006, 0, 0, 8'd0, 8'd0);
    vec(1, 1, 0, 0, 16'h0000, 0, 16'hFFFC, 0, 1, 8'd0, 8'd0);
    vec(1, 1, 0, 0, 16'h0000, 0, 16'hFFFE, 0, 0, 8'd0, 8'd0);
    vec(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'd0, 8'd0);
    // Taken branch from 0010 to 0100
    vec(1, 0, 0, 1, 16'h0010, 0, 16'h0000, 0, 0, 8'd0, 8'd0);
    vec(1, 0, 1, 0, 16'h0100, 0, 16'h0010, 1, 1, 8'd0, 8'd0);
    vec(1, 0, 0, 0, 16'h0000, 1, 16'h0010, 1, 0, 8'd0, 8'd0);
    vec(1, 0, 0, 0, 16'h0000, 0, 16'h0100, 0, 1, 8'd1, 8'd1);
    // Not-taken branch with advance and br_valid held during the stall
    vec(1, 0, 0, 1, 16'h0010, 0, 16'h0100, 0, 0, 8'd1, 8'd1);
    vec(1, 1, 1, 0, 16'h0100, 0, 16'h0010, 1, 1, 8'd1, 8'd1);
    vec(1, 1, 1, 1, 16'h0300, 0, 16'h0010, 1, 0, 8'd1, 8'd1);
    vec(1, 0, 0, 0, 16'h0000, 0, 16'h0010, 0, 0, 8'd2, 8'd1);
    // jump + br_valid + advance: jump wins, no WAIT_CMP
    vec(1, 1, 1, 1, 16'h0200, 0, 16'h0010, 0, 0, 8'd2, 8'd1);
    vec(1, 0, 0, 0, 16'h0000, 0, 16'h0200, 0, 1, 8'd2, 8'd1);
    vec(1, 0, 0, 0, 16'h0000, 0, 16'h0200, 0, 0, 8'd2, 8'd1);
    // Reset asserted mid-WAIT_CMP with cmp_R=1 pending
    vec(1, 0, 1, 0, 16'h0300, 0, 16'h0200, 1, 0, 8'd2, 8'd1);
    vec(0, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 8'd0, 8'd0);
    vec(0, 0, 1, 0, 16'h0300, 1, 16'h0000, 1, 0, 8'd0, 8'd0);
    vec(1, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 8'd0, 8'd0);
    vec(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'd0, 8'd0);

    // 300 back-to-back taken branches; each new branch is issued in the
    // resolution cycle of the previous one.
    for (int i = 0; i < 300; i++) begin
      sat = (i > 255) ? 255 : i;
      if (i == 0) begin
        vec(1, 0, 1, 0, 16'h0040, 0, 16'h0000, 1, 0, 8'd0, 8'd0);
        vec(1, 0, 0, 0, 16'h0000, 1, 16'h0000, 1, 0, 8'd0, 8'd0);
      end else begin
        vec(1, 0, 1, 0, 16'h0040, 0, 16'h0040, 1, 1, sat[7:0], sat[7:0]);
        vec(1, 0, 0, 0, 16'h0000, 1, 16'h0040, 1, 0, sat[7:0], sat[7:0]);
      end
    end
    vec(1, 0, 0, 0, 16'h0000, 0, 16'h0040, 0, 1, 8'hFF, 8'hFF);
    vec(1, 0, 0, 0, 16'h0000, 0, 16'h0040, 0, 0, 8'hFF, 8'hFF);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge CLK);
    #1;
    n_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
